// File: rtl/fused_cnn_sched_pkg.sv
// fused_cnn_sched_pkg: shared FSM state type and geometry defaults for the PE tile scheduler
package fused_cnn_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;
    localparam int DEF_NUM_PE = 16;
    localparam int DEF_ADDR_W = 13;
endpackage

// File: rtl/pe_lane_mask.sv
// pe_lane_mask: per-PE lane valid for a tile starting at tile_col in a map of the given width
module pe_lane_mask #(
    parameter int NUM_PE = 16,
    parameter int DIM_W  = 8
) (
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  tile_col,
    output logic [NUM_PE-1:0] mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_PE; i++) mask[i] = 32'(tile_col) + i < 32'(width);
    end
endmodule

// File: rtl/pe_tile_scheduler.sv
// pe_tile_scheduler: walks the output map in NUM_PE-wide tiles, channel innermost, driving the PE array.
// Optional SCHED_PERF_EN adds busy/stall performance counters.
module pe_tile_scheduler
    import fused_cnn_sched_pkg::*;
#(
    parameter int NUM_PE    = DEF_NUM_PE,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DIM_W     = 8,
    parameter int CH_W      = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [CH_W-1:0]   cfg_channels,
    input  logic              stall_in,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              pe_en,
    output logic [NUM_PE-1:0] pe_valid,
    output logic [ADDR_W-1:0] base_addr,
    output logic [DIM_W-1:0]  tile_row,
    output logic [DIM_W-1:0]  tile_col
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);
    sched_state_e state, state_n;
    logic [DIM_W-1:0]  cfg_w, cfg_h, row, col;
    logic [CH_W-1:0]   cfg_c, ch;
    logic [ADDR_W-1:0] plane, plane_c, row_start, addr;
    logic [7:0]        drain_cnt;
    logic [NUM_PE-1:0] mask;
    logic              err_q, cfg_ok, accept, step, last_c, last_t, last_r, last_step, drain_end;

    pe_lane_mask #(.NUM_PE(NUM_PE), .DIM_W(DIM_W)) u_mask (.width(cfg_w), .tile_col(col), .mask(mask));

    // H*W as shift-and-add; only needed once per layer to hop between channel planes
    always_comb begin
        plane_c = '0;
        for (int i = 0; i < DIM_W; i++)
            if (cfg_height[i]) plane_c = plane_c + (ADDR_W'(cfg_width) << i);
    end

    always_comb begin
        cfg_ok    = cfg_width != '0 && cfg_height != '0 && cfg_channels != '0;
        accept    = state == IDLE && start && cfg_ok;
        step      = state == RUN && !stall_in;
        last_c    = ch == cfg_c - CH_W'(1);
        last_t    = 32'(col) + NUM_PE >= 32'(cfg_w);
        last_r    = row == cfg_h - DIM_W'(1);
        last_step = step && last_c && last_t && last_r;
        drain_end = drain_cnt == 8'(DRAIN_CYC - 1);
        state_n   = state == IDLE  ? (accept ? RUN : IDLE) :
                    state == RUN   ? (last_step ? (DRAIN_CYC == 0 ? DONE : DRAIN) : RUN) :
                    state == DRAIN ? (drain_end ? DONE : DRAIN) : IDLE;
        busy      = state != IDLE;
        done      = state == DONE;
        err_cfg   = err_q;
        pe_en     = step;
        pe_valid  = state == RUN ? mask : '0;
        base_addr = state == RUN ? addr : '0;
        tile_row  = state == RUN ? row : '0;
        tile_col  = state == RUN ? col : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            cfg_w     <= '0;
            cfg_h     <= '0;
            cfg_c     <= '0;
            plane     <= '0;
            ch        <= '0;
            row       <= '0;
            col       <= '0;
            row_start <= '0;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            err_q     <= state == IDLE && start && !cfg_ok;
            drain_cnt <= state == DRAIN ? drain_cnt + 8'd1 : '0;
            if (accept) begin
                cfg_w     <= cfg_width;
                cfg_h     <= cfg_height;
                cfg_c     <= cfg_channels;
                plane     <= plane_c;
                ch        <= '0;
                row       <= '0;
                col       <= '0;
                row_start <= '0;
                addr      <= '0;
            end
            if (step) begin
                if (!last_c) begin
                    ch   <= ch + CH_W'(1);
                    addr <= addr + plane;
                end else if (!last_t) begin
                    ch   <= '0;
                    col  <= col + DIM_W'(NUM_PE);
                    addr <= row_start + ADDR_W'(col) + ADDR_W'(NUM_PE);
                end else if (!last_r) begin
                    ch        <= '0;
                    col       <= '0;
                    row       <= row + DIM_W'(1);
                    row_start <= row_start + ADDR_W'(cfg_w);
                    addr      <= row_start + ADDR_W'(cfg_w);
                end
            end
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
            if (state == RUN && stall_in && !(&perf_stalls)) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// tb_pe_tile_scheduler: directed scoreboard bench for pe_tile_scheduler
module tb_pe_tile_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_width = '0, cfg_height = '0, cfg_channels = '0;
    logic        stall_in = 1'b0;
    logic        busy, done, err_cfg, pe_en;
    logic [15:0] pe_valid;
    logic [12:0] base_addr;
    logic [7:0]  tile_row, tile_col;
`ifdef SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    pe_tile_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channels(cfg_channels),
        .stall_in(stall_in), .busy(busy), .done(done), .err_cfg(err_cfg), .pe_en(pe_en),
        .pe_valid(pe_valid), .base_addr(base_addr), .tile_row(tile_row), .tile_col(tile_col)
`ifdef SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0, cyc = 0;
    int          exp_done = -1, err_seen = 0, err_cyc = -1;
    bit          done_flag = 0, busy_seen = 0;
    logic [47:0] sb[$];
    logic [63:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: observe at the falling edge, then advance past the rising edge
    task automatic cycle();
        logic [47:0] e;
        @(negedge clk);
        snap = {15'd0, busy, done, err_cfg, pe_en, pe_valid, base_addr, tile_row, tile_col};
        busy_seen = busy_seen | busy;
        if (err_cfg) begin
            err_seen++;
            err_cyc = cyc;
        end
        if (pe_en) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else begin
                e = sb.pop_front();
                chk("step", {16'd0, tile_row, tile_col, 3'd0, base_addr, pe_valid}, {16'd0, e});
            end
        end
        if (done) begin
            chk("done_cycle", 64'(cyc), 64'(exp_done));
            done_flag = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_model(input int w, input int h, input int c);
        logic [15:0] v;
        for (int r = 0; r < h; r++)
            for (int t = 0; t < w; t += 16)
                for (int k = 0; k < c; k++) begin
                    v = '0;
                    for (int i = 0; i < 16; i++) if (t + i < w) v[i] = 1'b1;
                    sb.push_back({8'(r), 8'(t), 3'd0, 13'(((k * h + r) * w + t) % 8192), v});
                end
    endtask

    task automatic launch(input int w, input int h, input int c, input logic [31:0] smask,
                          input int rel_done, input int restart_rel);
        int s;
        s = cyc;
        push_model(w, h, c);
        exp_done = s + rel_done;
        done_flag = 0;
        cfg_width = 8'(w);
        cfg_height = 8'(h);
        cfg_channels = 8'(c);
        for (int n = 0; n < rel_done + 20 && !done_flag; n++) begin
            start = n == 0 || (restart_rel != 0 && n == restart_rel);
            if (restart_rel != 0 && n == restart_rel) begin
                cfg_width = 8'd20;
                cfg_height = 8'd1;
                cfg_channels = 8'd2;
            end
            stall_in = n < 32 ? smask[n] : 1'b0;
            cycle();
        end
        start = 0;
        stall_in = 0;
        chk("done_seen", 64'(done_flag), 64'd1);
        cycle();
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        exp_done = -1;
    endtask

    initial begin
        int s;
        cycle();
        cycle();
        reset = 0;
        cycle();
        chk("reset_outputs", snap, 64'd0);

        launch(16, 2, 1, 32'h0, 5, 0);
        launch(20, 1, 2, 32'h0, 7, 0);
        launch(16, 2, 1, 32'h1C, 8, 0);
        launch(16, 2, 1, 32'h0, 5, 2);
        launch(5, 2, 3, 32'h0, 9, 0);
        launch(255, 1, 1, 32'h0, 19, 0);
        launch(20, 2, 2, 32'h0A, 13, 0);

        for (int k = 0; k < 2; k++) begin
            err_seen = 0;
            busy_seen = 0;
            s = cyc;
            cfg_width = k == 0 ? 8'd16 : 8'd0;
            cfg_height = 8'd2;
            cfg_channels = k == 0 ? 8'd0 : 8'd1;
            start = 1;
            cycle();
            start = 0;
            for (int n = 0; n < 4; n++) cycle();
            chk("err_pulses", 64'(err_seen), 64'd1);
            chk("err_cycle", 64'(err_cyc), 64'(s + 1));
            chk("err_busy", 64'(busy_seen), 64'd0);
        end

        s = cyc;
        push_model(20, 1, 2);
        cfg_width = 8'd20;
        cfg_height = 8'd1;
        cfg_channels = 8'd2;
        start = 1;
        cycle();
        start = 0;
        cycle();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        sb.delete();
        cycle();
        chk("abort_outputs", snap, 64'd0);
        for (int n = 0; n < 8; n++) cycle();
        chk("abort_no_done", 64'(snap[48:47]), 64'd0);
        launch(20, 1, 2, 32'h0, 7, 0);

        launch(200, 200, 2, 32'h0, 5203, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
